int_issue_queue: RTL and testbench

- Parametrised integer issue queue; successor to the fixed 16-entry, 2-port single-execute queue inside the integer block.
- Generalised in depth, enqueue width, issue width, wakeup source count and source count.
- Adds over the previous queue: oldest-first select via age matrix, same-cycle wakeup bypass at enqueue, ROB-age squash, and replay/finish feedback by entry index.
- Sits between the int dispatch steering and the FU read/bypass stage (s0 issue, s1 regfile read).

---
 rtl/int_issue_queue.sv | 208 ++++++++++++++++++++
 tb/tb_int_issue_queue.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_issue_queue.sv
// Integer issue queue: age-matrix oldest-first select, wakeup, squash,
// and replay/finish feedback by entry index.
module int_issue_queue #(
  parameter int DEPTH           = 16,
  parameter int ENQ_NUM         = 2,
  parameter int DEQ_NUM         = 2,
  parameter int SRC_NUM         = 2,
  parameter int WAKE_NUM        = 6,
  parameter int INTERNAL_WAKEUP = 1,
  parameter int PRIDX_W         = 7,
  parameter int ROB_W           = 6,
  parameter int PAYLOAD_W       = 64,
  localparam int IDX_W          = $clog2(DEPTH)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_squash_vld,
  input  logic [ROB_W:0]                           i_squash_rob,
  output logic                                     o_can_enq,
  input  logic [ENQ_NUM-1:0]                       i_enq_req,
  input  logic [ENQ_NUM-1:0][ROB_W:0]              i_enq_rob,
  input  logic [ENQ_NUM-1:0]                       i_enq_rd_wen,
  input  logic [ENQ_NUM-1:0][PRIDX_W-1:0]          i_enq_rd,
  input  logic [ENQ_NUM-1:0][SRC_NUM-1:0][PRIDX_W-1:0] i_enq_src,
  input  logic [ENQ_NUM-1:0][SRC_NUM-1:0]          i_enq_src_rdy,
  input  logic [ENQ_NUM-1:0][PAYLOAD_W-1:0]        i_enq_payload,
  input  logic                                     i_stall,
  output logic [DEQ_NUM-1:0]                       o_issue_vld,
  output logic [DEQ_NUM-1:0][IDX_W-1:0]            o_issue_idx,
  output logic [DEQ_NUM-1:0][PAYLOAD_W-1:0]        o_issue_payload,
  output logic [DEQ_NUM-1:0][SRC_NUM-1:0][PRIDX_W-1:0] o_issue_src,
  input  logic [DEQ_NUM-1:0]                       i_fb_finish,
  input  logic [DEQ_NUM-1:0]                       i_fb_replay,
  input  logic [DEQ_NUM-1:0][IDX_W-1:0]            i_fb_idx,
  output logic [DEQ_NUM-1:0]                       o_wake_vld,
  output logic [DEQ_NUM-1:0][PRIDX_W-1:0]          o_wake_rd,
  input  logic [WAKE_NUM-1:0]                      i_wake_vld,
  input  logic [WAKE_NUM-1:0][PRIDX_W-1:0]         i_wake_rd,
  output logic [IDX_W:0]                           o_free_cnt
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] issued;
  logic [DEPTH-1:0] vld_nxt;
  logic [DEPTH-1:0] issued_nxt;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] rd_wen;
  logic [SRC_NUM-1:0] rdy [DEPTH];
  logic [SRC_NUM-1:0][PRIDX_W-1:0] src [DEPTH];
  logic [PRIDX_W-1:0] rd [DEPTH];
  logic [ROB_W:0] rob [DEPTH];
  logic [PAYLOAD_W-1:0] payload [DEPTH];
  logic [DEPTH-1:0] age [DEPTH];
  logic [IDX_W:0] older [DEPTH];
  logic [IDX_W:0] free_cnt;

  logic [ENQ_NUM-1:0] enq_fire;
  logic [ENQ_NUM-1:0][IDX_W-1:0] enq_slot;
  logic [DEQ_NUM-1:0] sel_vld;
  logic [DEQ_NUM-1:0][IDX_W-1:0] sel_idx;
  logic issue_go;

  function automatic logic younger(
    input logic [ROB_W:0] a,
    input logic [ROB_W:0] b
  );
    if (a[ROB_W] == b[ROB_W])
      return a[ROB_W-1:0] > b[ROB_W-1:0];
    return a[ROB_W-1:0] < b[ROB_W-1:0];
  endfunction

  function automatic logic woken(input logic [PRIDX_W-1:0] preg);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKE_NUM; w++)
      if (i_wake_vld[w] && i_wake_rd[w] == preg)
        hit = 1'b1;
    for (int p = 0; p < DEQ_NUM; p++)
      if (o_wake_vld[p] && o_wake_rd[p] == preg)
        hit = 1'b1;
    return hit;
  endfunction

  assign o_free_cnt = free_cnt;
  assign o_can_enq  = (free_cnt >= (IDX_W+1)'(ENQ_NUM))
                    && !i_squash_vld;
  assign enq_fire   = i_enq_req & {ENQ_NUM{o_can_enq}};
  assign issue_go   = !i_stall && !i_squash_vld;

  // k-th lowest free slot goes to enqueue port k
  always_comb begin
    int n;
    n = 0;
    enq_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!vld[i]) begin
        for (int k = 0; k < ENQ_NUM; k++)
          if (n == k)
            enq_slot[k] = IDX_W'(i);
        n++;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      cand[i] = vld[i] && !issued[i] && (&rdy[i]);
    for (int i = 0; i < DEPTH; i++) begin
      older[i] = '0;
      for (int j = 0; j < DEPTH; j++)
        if (j != i && cand[j] && age[j][i])
          older[i] = older[i] + 1'b1;
    end
    // a candidate with p older candidates belongs to port p
    for (int p = 0; p < DEQ_NUM; p++) begin
      sel_vld[p] = 1'b0;
      sel_idx[p] = '0;
      for (int i = 0; i < DEPTH; i++)
        if (cand[i] && older[i] == (IDX_W+1)'(p)) begin
          sel_vld[p] = 1'b1;
          sel_idx[p] = IDX_W'(i);
        end
    end
  end

  always_comb begin
    for (int p = 0; p < DEQ_NUM; p++) begin
      o_issue_vld[p]     = sel_vld[p] && issue_go;
      o_issue_idx[p]     = sel_idx[p];
      o_issue_payload[p] = payload[sel_idx[p]];
      o_issue_src[p]     = src[sel_idx[p]];
      o_wake_vld[p]      = (INTERNAL_WAKEUP != 0) && o_issue_vld[p]
                         && rd_wen[sel_idx[p]];
      o_wake_rd[p]       = rd[sel_idx[p]];
    end
  end

  always_comb begin
    vld_nxt    = vld;
    issued_nxt = issued;
    for (int p = 0; p < DEQ_NUM; p++)
      if (o_issue_vld[p])
        issued_nxt[sel_idx[p]] = 1'b1;
    for (int p = 0; p < DEQ_NUM; p++)
      if (i_fb_replay[p] && vld[i_fb_idx[p]])
        issued_nxt[i_fb_idx[p]] = 1'b0;
    for (int p = 0; p < DEQ_NUM; p++)
      if (i_fb_finish[p] && vld[i_fb_idx[p]]) begin
        vld_nxt[i_fb_idx[p]]    = 1'b0;
        issued_nxt[i_fb_idx[p]] = 1'b0;
      end
    for (int i = 0; i < DEPTH; i++)
      if (i_squash_vld && vld[i] && younger(rob[i], i_squash_rob)) begin
        vld_nxt[i]    = 1'b0;
        issued_nxt[i] = 1'b0;
      end
    for (int k = 0; k < ENQ_NUM; k++)
      if (enq_fire[k]) begin
        vld_nxt[enq_slot[k]]    = 1'b1;
        issued_nxt[enq_slot[k]] = 1'b0;
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld      <= '0;
      issued   <= '0;
      free_cnt <= (IDX_W+1)'(DEPTH);
      for (int i = 0; i < DEPTH; i++)
        age[i] <= '0;
    end else begin
      vld      <= vld_nxt;
      issued   <= issued_nxt;
      free_cnt <= (IDX_W+1)'(DEPTH - $countones(vld_nxt));
      // new entries: every resident is older; row then orders ports
      for (int k = 0; k < ENQ_NUM; k++)
        if (enq_fire[k])
          for (int j = 0; j < DEPTH; j++)
            age[j][enq_slot[k]] <= 1'b1;
      for (int k = 0; k < ENQ_NUM; k++)
        if (enq_fire[k]) begin
          age[enq_slot[k]] <= '0;
          for (int k2 = k + 1; k2 < ENQ_NUM; k2++)
            if (enq_fire[k2])
              age[enq_slot[k]][enq_slot[k2]] <= 1'b1;
        end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      for (int s = 0; s < SRC_NUM; s++)
        if (woken(src[i][s]))
          rdy[i][s] <= 1'b1;
    for (int k = 0; k < ENQ_NUM; k++)
      if (enq_fire[k]) begin
        src[enq_slot[k]]     <= i_enq_src[k];
        rd[enq_slot[k]]      <= i_enq_rd[k];
        rd_wen[enq_slot[k]]  <= i_enq_rd_wen[k];
        rob[enq_slot[k]]     <= i_enq_rob[k];
        payload[enq_slot[k]] <= i_enq_payload[k];
        for (int s = 0; s < SRC_NUM; s++)
          rdy[enq_slot[k]][s] <= i_enq_src_rdy[k][s]
                               | woken(i_enq_src[k][s]);
      end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue with an issue scoreboard.
// Expected issues are queued when stimulus is driven and popped on issue.
module tb_int_issue_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic i_squash_vld;
  logic [6:0] i_squash_rob;
  logic o_can_enq;
  logic [1:0] i_enq_req;
  logic [1:0][6:0] i_enq_rob;
  logic [1:0] i_enq_rd_wen;
  logic [1:0][6:0] i_enq_rd;
  logic [1:0][1:0][6:0] i_enq_src;
  logic [1:0][1:0] i_enq_src_rdy;
  logic [1:0][63:0] i_enq_payload;
  logic i_stall;
  logic [1:0] o_issue_vld;
  logic [1:0][3:0] o_issue_idx;
  logic [1:0][63:0] o_issue_payload;
  logic [1:0][1:0][6:0] o_issue_src;
  logic [1:0] i_fb_finish;
  logic [1:0] i_fb_replay;
  logic [1:0][3:0] i_fb_idx;
  logic [1:0] o_wake_vld;
  logic [1:0][6:0] o_wake_rd;
  logic [5:0] i_wake_vld;
  logic [5:0][6:0] i_wake_rd;
  logic [4:0] o_free_cnt;

  int_issue_queue dut (
    .clk             (clk),
    .rst             (rst),
    .i_squash_vld    (i_squash_vld),
    .i_squash_rob    (i_squash_rob),
    .o_can_enq       (o_can_enq),
    .i_enq_req       (i_enq_req),
    .i_enq_rob       (i_enq_rob),
    .i_enq_rd_wen    (i_enq_rd_wen),
    .i_enq_rd        (i_enq_rd),
    .i_enq_src       (i_enq_src),
    .i_enq_src_rdy   (i_enq_src_rdy),
    .i_enq_payload   (i_enq_payload),
    .i_stall         (i_stall),
    .o_issue_vld     (o_issue_vld),
    .o_issue_idx     (o_issue_idx),
    .o_issue_payload (o_issue_payload),
    .o_issue_src     (o_issue_src),
    .i_fb_finish     (i_fb_finish),
    .i_fb_replay     (i_fb_replay),
    .i_fb_idx        (i_fb_idx),
    .o_wake_vld      (o_wake_vld),
    .o_wake_rd       (o_wake_rd),
    .i_wake_vld      (i_wake_vld),
    .i_wake_rd       (i_wake_rd),
    .o_free_cnt      (o_free_cnt)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [63:0] pay;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] idx, input logic [63:0] pay);
    exp_t e;
    e.idx = idx;
    e.pay = pay;
    sb.push_back(e);
  endtask

  task automatic chk_issue(input string tag, input int n);
    logic [1:0] m;
    m = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
    chk({tag, ".vld"}, 64'(o_issue_vld), 64'(m));
    for (int p = 0; p < n; p++) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL %s.sb: observed issue, expected empty scoreboard", tag);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".idx"}, 64'(o_issue_idx[p]), 64'(e.idx));
        chk({tag, ".pay"}, o_issue_payload[p], e.pay);
      end
    end
  endtask

  task automatic enq(input logic [1:0] req, input logic [6:0] rob0,
                     input logic [6:0] rob1, input logic [6:0] srcp,
                     input logic r, input logic [63:0] p0,
                     input logic [63:0] p1);
    i_enq_req     = req;
    i_enq_rob[0]  = rob0;
    i_enq_rob[1]  = rob1;
    i_enq_rd_wen  = 2'b11;
    i_enq_rd[0]   = 7'd64;
    i_enq_rd[1]   = 7'd65;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 2; j++) begin
        i_enq_src[k][j]     = srcp;
        i_enq_src_rdy[k][j] = r;
      end
    i_enq_payload[0] = p0;
    i_enq_payload[1] = p1;
    tick();
    i_enq_req = 2'b00;
  endtask

  task automatic fb(input logic [1:0] fin, input logic [1:0] rep,
                    input logic [3:0] idx0, input logic [3:0] idx1);
    i_fb_finish = fin;
    i_fb_replay = rep;
    i_fb_idx[0] = idx0;
    i_fb_idx[1] = idx1;
    tick();
    i_fb_finish = 2'b00;
    i_fb_replay = 2'b00;
  endtask

  task automatic wake(input logic [6:0] preg);
    i_wake_vld   = 6'b000001;
    i_wake_rd[0] = preg;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst.issue", 64'(o_issue_vld), 64'd0);
    chk("rst.wake", 64'(o_wake_vld), 64'd0);
    chk("rst.free", 64'(o_free_cnt), 64'd16);
    chk("rst.can_enq", 64'(o_can_enq), 64'd1);
  endtask

  task automatic fill16();
    for (int c = 0; c < 8; c++)
      enq(2'b11, 7'(2 * c), 7'(2 * c + 1), 7'd20, 1'b0,
          64'(32'hF00 + 2 * c), 64'(32'hF01 + 2 * c));
  endtask

  initial begin
    rst = 1'b1;
    i_squash_vld = 1'b0;
    i_squash_rob = '0;
    i_enq_req = '0;
    i_enq_rob = '0;
    i_enq_rd_wen = '0;
    i_enq_rd = '0;
    i_enq_src = '0;
    i_enq_src_rdy = '0;
    i_enq_payload = '0;
    i_stall = 1'b0;
    i_fb_finish = '0;
    i_fb_replay = '0;
    i_fb_idx = '0;
    i_wake_vld = '0;
    i_wake_rd = '0;

    // two ready ops issue together the cycle after enqueue
    do_reset();
    enq(2'b11, 7'd0, 7'd1, 7'd3, 1'b1, 64'hA0, 64'hA1);
    push(4'd0, 64'hA0);
    push(4'd1, 64'hA1);
    #1;
    chk_issue("basic", 2);
    chk("basic.free", 64'(o_free_cnt), 64'd14);
    chk("basic.wake", 64'(o_wake_vld), 64'b11);
    chk("basic.wrd0", 64'(o_wake_rd[0]), 64'd64);
    chk("basic.wrd1", 64'(o_wake_rd[1]), 64'd65);
    tick();
    fb(2'b11, 2'b00, 4'd0, 4'd1);
    chk("basic.freed", 64'(o_free_cnt), 64'd16);

    // late wakeup
    enq(2'b01, 7'd2, 7'd0, 7'd5, 1'b0, 64'hA5, 64'h0);
    chk_issue("late.w1", 0);
    tick();
    chk_issue("late.w2", 0);
    tick();
    wake(7'd5);
    #1;
    chk_issue("late.w3", 0);
    tick();
    i_wake_vld = '0;
    push(4'd0, 64'hA5);
    #1;
    chk_issue("late.go", 1);
    tick();
    fb(2'b01, 2'b00, 4'd0, 4'd0);

    // wakeup in the enqueue cycle
    wake(7'd6);
    enq(2'b01, 7'd3, 7'd0, 7'd6, 1'b0, 64'hA6, 64'h0);
    i_wake_vld = '0;
    push(4'd0, 64'hA6);
    #1;
    chk_issue("bypass", 1);
    tick();
    fb(2'b01, 2'b00, 4'd0, 4'd0);

    // full queue and blocked enqueue
    do_reset();
    fill16();
    chk("full.free", 64'(o_free_cnt), 64'd0);
    chk("full.can_enq", 64'(o_can_enq), 64'd0);
    chk_issue("full", 0);
    i_enq_req = 2'b11;
    tick();
    i_enq_req = 2'b00;
    chk("full.ignored", 64'(o_free_cnt), 64'd0);
    fb(2'b11, 2'b00, 4'd3, 4'd7);
    chk("full.free2", 64'(o_free_cnt), 64'd2);
    chk("full.can_enq2", 64'(o_can_enq), 64'd1);

    // replay then finish+replay
    do_reset();
    enq(2'b11, 7'd0, 7'd1, 7'd20, 1'b0, 64'hE0, 64'hE1);
    enq(2'b11, 7'd2, 7'd3, 7'd20, 1'b0, 64'hE2, 64'hE3);
    enq(2'b01, 7'd4, 7'd0, 7'd20, 1'b1, 64'hB4, 64'h0);
    push(4'd4, 64'hB4);
    #1;
    chk_issue("replay.first", 1);
    tick();
    chk_issue("replay.held", 0);
    i_fb_replay = 2'b01;
    i_fb_idx[0] = 4'd4;
    #1;
    chk_issue("replay.req", 0);
    tick();
    i_fb_replay = 2'b00;
    push(4'd4, 64'hB4);
    #1;
    chk_issue("replay.again", 1);
    tick();
    fb(2'b01, 2'b01, 4'd4, 4'd0);
    chk_issue("replay.fin", 0);
    chk("replay.free", 64'(o_free_cnt), 64'd12);
    tick();
    chk_issue("replay.gone", 0);

    // squash with wrap flag
    do_reset();
    enq(2'b11, 7'h02, 7'h05, 7'd20, 1'b0, 64'hC2, 64'hC5);
    enq(2'b01, 7'h41, 7'h00, 7'd20, 1'b0, 64'hC9, 64'h0);
    i_squash_vld = 1'b1;
    i_squash_rob = 7'h03;
    i_enq_req = 2'b11;
    #1;
    chk("squash.can_enq", 64'(o_can_enq), 64'd0);
    chk_issue("squash.cycle", 0);
    tick();
    i_squash_vld = 1'b0;
    i_enq_req = 2'b00;
    chk("squash.free", 64'(o_free_cnt), 64'd15);
    wake(7'd20);
    tick();
    i_wake_vld = '0;
    push(4'd0, 64'hC2);
    #1;
    chk_issue("squash.survivor", 1);

    // age order 9,2,6,0 with a stall
    do_reset();
    fill16();
    fb(2'b11, 2'b00, 4'd9, 4'd10);
    enq(2'b01, 7'h10, 7'd0, 7'd30, 1'b0, 64'hD9, 64'h0);
    fb(2'b01, 2'b00, 4'd2, 4'd0);
    enq(2'b01, 7'h11, 7'd0, 7'd30, 1'b0, 64'hD2, 64'h0);
    fb(2'b01, 2'b00, 4'd6, 4'd0);
    enq(2'b01, 7'h12, 7'd0, 7'd30, 1'b0, 64'hD6, 64'h0);
    fb(2'b01, 2'b00, 4'd0, 4'd0);
    enq(2'b01, 7'h13, 7'd0, 7'd30, 1'b0, 64'hD0, 64'h0);
    chk("age.free", 64'(o_free_cnt), 64'd1);
    chk("age.can_enq", 64'(o_can_enq), 64'd0);
    wake(7'd30);
    #1;
    chk_issue("age.pre", 0);
    tick();
    i_wake_vld = '0;
    i_stall = 1'b1;
    #1;
    chk_issue("age.stall", 0);
    tick();
    i_stall = 1'b0;
    push(4'd9, 64'hD9);
    push(4'd2, 64'hD2);
    #1;
    chk_issue("age.first", 2);
    chk("age.wake", 64'(o_wake_vld), 64'b11);
    tick();
    push(4'd6, 64'hD6);
    push(4'd0, 64'hD0);
    #1;
    chk_issue("age.second", 2);
    tick();
    chk_issue("age.done", 0);

    chk("sb.empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
